// File: rtl/pll_pkg.sv
// Shared types and 50 MHz default timing constants for the PLL reset/lock sequencer.
package pll_pkg;

  typedef enum logic [1:0] {
    PLLRST   = 2'd0,
    WAITLOCK = 2'd1,
    STABLE   = 2'd2,
    RUN      = 2'd3
  } pll_state_e;

  localparam int unsigned PLL_RST_CYCLES_50M = 16;
  localparam int unsigned LOCK_TIMEOUT_50M   = 500000;
  localparam int unsigned STABLE_CYCLES_50M  = 50000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchroniser; both flops reset asynchronously to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset/lock sequencer: pulses pll_rst, qualifies lock stability, then releases core_rst.
module pll_reset_seq
  import pll_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = PLL_RST_CYCLES_50M,
  parameter int unsigned LOCK_TIMEOUT   = LOCK_TIMEOUT_50M,
  parameter int unsigned STABLE_CYCLES  = STABLE_CYCLES_50M,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       soft_rst,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic [7:0] lock_loss_cnt,
  output logic [1:0] state_dbg
);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  pll_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             locked_s;
  logic             loss_event;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // Loss is counted even when soft_rst wins the transition in the same cycle.
  assign loss_event = (state == RUN) && !locked_s;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (soft_rst) begin
      state_nxt = PLLRST;
      cnt_nxt   = '0;
    end else begin
      case (state)
        PLLRST: begin
          if (cnt == PLL_RST_LAST) begin
            state_nxt = WAITLOCK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        WAITLOCK: begin
          if (locked_s) begin
            state_nxt = STABLE;
            cnt_nxt   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state_nxt = PLLRST;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_nxt = WAITLOCK;
            cnt_nxt   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_nxt = PLLRST;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = PLLRST;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they toggle with the state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state         <= PLLRST;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      core_rst      <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pll_rst  <= (state_nxt == PLLRST);
      core_rst <= (state_nxt != RUN);
      ready    <= (state_nxt == RUN);
      if (loss_event) lock_loss_cnt <= sat_inc8(lock_loss_cnt);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq with short timing parameters.
module tb_pll_reset_seq;

  localparam int PR = 4;
  localparam int LT = 20;
  localparam int SC = 8;

  logic       refclk = 1'b0;
  logic       rst;
  logic       locked;
  logic       soft_rst;
  logic       pll_rst;
  logic       core_rst;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  always #5 refclk = ~refclk;

  pll_reset_seq #(
    .PLL_RST_CYCLES (PR),
    .LOCK_TIMEOUT   (LT),
    .STABLE_CYCLES  (SC),
    .CNT_W          (8)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .locked        (locked),
    .soft_rst      (soft_rst),
    .pll_rst       (pll_rst),
    .core_rst      (core_rst),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt),
    .state_dbg     (state_dbg)
  );

  // Reference model: phase index, cycles spent in phase, sync history, loss tally.
  int m_phase;
  int m_time;
  int m_loss;
  bit m_s1, m_s2;

  task automatic model_reset();
    m_phase = 0; m_time = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_edge();
    bit seen = m_s2;
    int nxt  = m_phase;
    m_s2 = m_s1;
    m_s1 = locked;
    if (m_phase == 3 && !seen && m_loss < 255) m_loss++;
    if (soft_rst) nxt = 0;
    else begin
      case (m_phase)
        0: if (m_time == PR - 1) nxt = 1;
        1: if (seen) nxt = 2; else if (m_time == LT - 1) nxt = 0;
        2: if (!seen) nxt = 1; else if (m_time == SC - 1) nxt = 3;
        default: if (!seen) nxt = 0;
      endcase
    end
    if (soft_rst || nxt != m_phase) m_time = 0;
    else if (m_phase != 3) m_time++;
    m_phase = nxt;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("model_pll_rst", 32'(pll_rst), 32'(m_phase == 0));
    chk("model_core_rst", 32'(core_rst), 32'(m_phase != 3));
    chk("model_ready", 32'(ready), 32'(m_phase == 3));
    chk("model_state", 32'(state_dbg), 32'(m_phase));
    chk("model_loss", 32'(lock_loss_cnt), 32'(m_loss));
  endtask

  task automatic tick();
    @(posedge refclk);
    if (rst) model_reset(); else model_edge();
    #1;
    compare_model();
  endtask

  task automatic wait_state(input int st, input int budget, output int n);
    n = 0;
    while (state_dbg != 2'(st)) begin
      if (n >= budget) begin
        chk("wait_state_timeout", 32'(state_dbg), 32'(st));
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit l;
    bit s;
    bit pll;
    bit core;
    bit rdy;
    int st;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, rise, lvl;

    tbl[0]  = '{1, 0, 1, 1, 0, 0};
    tbl[1]  = '{1, 0, 1, 1, 0, 0};
    tbl[2]  = '{1, 0, 1, 1, 0, 0};
    tbl[3]  = '{1, 0, 0, 1, 0, 1};
    tbl[4]  = '{1, 0, 0, 1, 0, 2};
    tbl[5]  = '{1, 0, 0, 1, 0, 2};
    tbl[6]  = '{1, 1, 1, 1, 0, 0};
    tbl[7]  = '{1, 0, 1, 1, 0, 0};
    tbl[8]  = '{1, 0, 1, 1, 0, 0};
    tbl[9]  = '{1, 0, 1, 1, 0, 0};
    tbl[10] = '{1, 0, 0, 1, 0, 1};
    tbl[11] = '{1, 0, 0, 1, 0, 2};

    rst = 1'b1; locked = 1'b1; soft_rst = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("reset_pll_rst", 32'(pll_rst), 1);
    chk("reset_core_rst", 32'(core_rst), 1);
    chk("reset_ready", 32'(ready), 0);
    chk("reset_state", 32'(state_dbg), 0);
    chk("reset_loss", 32'(lock_loss_cnt), 0);
    rst = 1'b0;

    // Vector table from reset release, including a soft_rst from STABLE.
    for (int i = 0; i < 12; i++) begin
      locked   = tbl[i].l;
      soft_rst = tbl[i].s;
      tick();
      chk($sformatf("tbl%0d_pll_rst", i), 32'(pll_rst), 32'(tbl[i].pll));
      chk($sformatf("tbl%0d_core_rst", i), 32'(core_rst), 32'(tbl[i].core));
      chk($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_state", i), 32'(state_dbg), 32'(tbl[i].st));
    end
    soft_rst = 1'b0;

    // Lock never arrives: 4-high / 20-low pll_rst cadence.
    locked = 1'b0;
    reset_pulse();
    hi = 0; rise = -1; lvl = 1;
    for (int p = 1; p <= 48; p++) begin
      tick();
      if (pll_rst) hi++;
      if (pll_rst && !lvl && rise < 0) rise = p;
      lvl = pll_rst;
      chk("timeout_core_rst", 32'(core_rst), 1);
    end
    chk("timeout_high_cycles", 32'(hi), 32'(2 * PR));
    chk("timeout_period", 32'(rise), 32'(PR + LT));
    chk("timeout_loss", 32'(lock_loss_cnt), 0);

    // Power-up: lock rises 5 cycles after pll_rst falls.
    reset_pulse();
    n = 0;
    while (pll_rst && n < 50) begin tick(); n++; end
    chk("pwrup_pll_rst_len", 32'(n), 32'(PR));
    repeat (4) tick();
    locked = 1'b1;
    wait_state(2, 10, n);
    chk("lock_to_stable_edges", 32'(n), 3);
    n = 0;
    while (core_rst && n < 40) begin tick(); n++; end
    chk("stable_len", 32'(n), 32'(SC));
    chk("run_ready", 32'(ready), 1);
    chk("run_state", 32'(state_dbg), 3);

    // One-cycle lock drop in RUN: core_rst on the third edge.
    locked = 1'b0;
    tick();
    locked = 1'b1;
    chk("drop_edge1_core_rst", 32'(core_rst), 0);
    tick();
    chk("drop_edge2_core_rst", 32'(core_rst), 0);
    tick();
    chk("drop_edge3_core_rst", 32'(core_rst), 1);
    chk("drop_edge3_pll_rst", 32'(pll_rst), 1);
    chk("drop_loss", 32'(lock_loss_cnt), 1);
    wait_state(3, 60, n);
    chk("reseq_len", 32'(n), 32'(PR + 1 + SC));

    // Glitch seen at STABLE cycle 5 restarts the qualification.
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    wait_state(2, 40, n);
    repeat (3) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    chk("glitch_still_stable", 32'(state_dbg), 2);
    tick();
    chk("glitch_to_waitlock", 32'(state_dbg), 1);
    chk("glitch_loss", 32'(lock_loss_cnt), 1);
    wait_state(2, 10, n);
    wait_state(3, 40, n);
    chk("glitch_full_stable", 32'(n), 32'(SC));

    // soft_rst coincident with a lock loss in RUN, then held 10 more cycles.
    locked = 1'b0;
    tick();
    tick();
    soft_rst = 1'b1;
    tick();
    chk("soft_loss_state", 32'(state_dbg), 0);
    chk("soft_loss_cnt", 32'(lock_loss_cnt), 2);
    hi = 1;
    locked = 1'b1;
    repeat (10) begin tick(); if (pll_rst) hi++; end
    soft_rst = 1'b0;
    n = 0;
    while (pll_rst && n < 20) begin tick(); n++; if (pll_rst) hi++; end
    chk("soft_hold_pll_rst_len", 32'(hi), 32'(10 + PR));

    // Saturation of the lock-loss counter.
    for (int k = 0; k < 300; k++) begin
      wait_state(3, 60, n);
      locked = 1'b0;
      tick();
      locked = 1'b1;
      wait_state(0, 10, n);
    end
    chk("loss_saturated", 32'(lock_loss_cnt), 255);

    // Async reset mid-STABLE, observed before any clock edge.
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    wait_state(2, 40, n);
    repeat (3) tick();
    rst = 1'b1;
    model_reset();
    #2;
    chk("arst_pll_rst", 32'(pll_rst), 1);
    chk("arst_core_rst", 32'(core_rst), 1);
    chk("arst_ready", 32'(ready), 0);
    chk("arst_loss", 32'(lock_loss_cnt), 0);
    chk("arst_state", 32'(state_dbg), 0);
    tick();
    rst = 1'b0;
    n = 0;
    while (pll_rst && n < 50) begin tick(); n++; end
    chk("arst_pll_rst_len", 32'(n), 32'(PR));

    // Randomised lock behaviour and soft resets against the model.
    for (int r = 0; r < 3000; r++) begin
      if ($urandom_range(0, 11) == 0) locked = ~locked;
      soft_rst = ($urandom_range(0, 59) == 0);
      tick();
    end
    soft_rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
